// File: rtl/ps2_player_inputs.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ps2_player_inputs
//
// Turns a PS/2 keyboard into held-key state for two players sharing one
// keyboard. The PS/2 clock and data lines are synchronized into the system
// clock domain. Each falling edge of the keyboard clock shifts in one bit of
// an 11-bit frame. Accepted scancode bytes then drive a small decoder that
// tracks the E0 (extended) and F0 (break) prefixes. That decoder sets or
// clears one bit per mapped key.
//
// Parameters
//   TIMEOUT_CYCLES  clk cycles without a PS/2 falling edge before a partially
//                   received frame is abandoned
//
// Ports
//   clk        system clock (100 MHz), the only clock of the block
//   reset      asynchronous active-low reset
//   ps2_clk    keyboard clock line, asynchronous to clk
//   ps2_data   keyboard data line, asynchronous to clk
//   p1_inputs  player 1 held keys {shield, attack, down, up, right, left, center}
//   p2_inputs  player 2 held keys, same bit layout as p1_inputs
//   rx_byte    last scancode byte accepted by the frame receiver
//   rx_valid   one-cycle pulse when rx_byte is updated
//   frame_err  one-cycle pulse when a frame is rejected or times out
//
// Build options
//   PS2_PARITY_CHECK_EN  when defined, frames with bad odd parity are rejected;
//                        when undefined, the parity bit is received but ignored
// ---------------------------------------------------------------------------
module ps2_player_inputs #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [6:0] p1_inputs,
  output logic [6:0] p2_inputs,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int              TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TLIMIT = TW'(TIMEOUT_CYCLES);

  // Key bit positions inside a player vector
  localparam logic [2:0] KEY_CENTER = 3'd0;
  localparam logic [2:0] KEY_LEFT   = 3'd1;
  localparam logic [2:0] KEY_RIGHT  = 3'd2;
  localparam logic [2:0] KEY_UP     = 3'd3;
  localparam logic [2:0] KEY_DOWN   = 3'd4;
  localparam logic [2:0] KEY_ATTACK = 3'd5;
  localparam logic [2:0] KEY_SHIELD = 3'd6;

  // Prefix tracking for the scancode decoder
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  logic          clk_s1;
  logic          clk_s2;
  logic          clk_s3;
  logic          data_s1;
  logic          data_s2;
  logic          ps2_fall;

  logic [3:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [TW-1:0] timeout_cnt;
  logic          timed_out;
  logic          parity_ok;

  logic [1:0]    state;
  logic          is_ext;
  logic          is_brk;
  logic          key_hit;
  logic          key_p2;
  logic [2:0]    key_bit;
  logic [6:0]    key_mask;

  // Two-flop synchronizers for both PS/2 lines. A third flop on the clock
  // line gives the previous synchronized value for falling-edge detection.
  // All flops reset to 1, which is the idle level of the PS/2 bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  assign ps2_fall = clk_s3 & ~clk_s2;

  // A timeout only matters while a frame is in progress. When idle, the
  // counter simply sits at its saturation value.
  assign timed_out = (bit_cnt != 4'd0) && (timeout_cnt == TLIMIT);

`ifdef PS2_PARITY_CHECK_EN
  // Odd parity: data bits plus parity bit must contain an odd number of ones
  assign parity_ok = ^{shift_reg, parity_bit};
`else
  logic parity_unused;
  assign parity_unused = parity_bit;
  assign parity_ok     = 1'b1;
`endif

  // Frame receiver. bit_cnt 0 waits for a start bit. Counts 1..8 shift data
  // in LSB first, count 9 takes the parity bit, and count 10 checks the stop
  // bit. A start bit sampled high is treated as line noise and ignored
  // silently. The status pulses appear on the cycle after the edge that
  // completes the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt     <= 4'd0;
      shift_reg   <= 8'h00;
      parity_bit  <= 1'b0;
      timeout_cnt <= '0;
      rx_byte     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (ps2_fall) begin
        timeout_cnt <= '0;
        case (bit_cnt)
          4'd0: begin
            if (!data_s2) begin
              bit_cnt <= 4'd1;
            end
          end
          4'd9: begin
            parity_bit <= data_s2;
            bit_cnt    <= 4'd10;
          end
          4'd10: begin
            bit_cnt <= 4'd0;
            if (data_s2 && parity_ok) begin
              rx_byte  <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: begin
            shift_reg <= {data_s2, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 4'd1;
          end
        endcase
      end else if (timed_out) begin
        bit_cnt   <= 4'd0;
        frame_err <= 1'b1;
      end else if (timeout_cnt != TLIMIT) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end
    end
  end

  assign is_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign is_brk = (state == ST_BRK) || (state == ST_EXT_BRK);

  // Scancode to key lookup. Extended codes are looked up in their own table
  // only, so a prefixed code never aliases to a plain key.
  always_comb begin
    key_hit = 1'b0;
    key_p2  = 1'b0;
    key_bit = KEY_CENTER;
    if (!is_ext) begin
      case (rx_byte)
        8'h1C: begin key_hit = 1'b1; key_bit = KEY_LEFT;   end
        8'h23: begin key_hit = 1'b1; key_bit = KEY_RIGHT;  end
        8'h1D: begin key_hit = 1'b1; key_bit = KEY_UP;     end
        8'h1B: begin key_hit = 1'b1; key_bit = KEY_DOWN;   end
        8'h2B: begin key_hit = 1'b1; key_bit = KEY_ATTACK; end
        8'h34: begin key_hit = 1'b1; key_bit = KEY_SHIELD; end
        8'h29: begin key_hit = 1'b1; key_bit = KEY_CENTER; end
        8'h4B: begin key_hit = 1'b1; key_p2 = 1'b1; key_bit = KEY_ATTACK; end
        8'h42: begin key_hit = 1'b1; key_p2 = 1'b1; key_bit = KEY_SHIELD; end
        8'h5A: begin key_hit = 1'b1; key_p2 = 1'b1; key_bit = KEY_CENTER; end
        default: ;
      endcase
    end else begin
      case (rx_byte)
        8'h6B: begin key_hit = 1'b1; key_p2 = 1'b1; key_bit = KEY_LEFT;  end
        8'h74: begin key_hit = 1'b1; key_p2 = 1'b1; key_bit = KEY_RIGHT; end
        8'h75: begin key_hit = 1'b1; key_p2 = 1'b1; key_bit = KEY_UP;    end
        8'h72: begin key_hit = 1'b1; key_p2 = 1'b1; key_bit = KEY_DOWN;  end
        default: ;
      endcase
    end
  end

  assign key_mask = 7'b0000001 << key_bit;

  // Scancode decoder. Prefix bytes only move the state. Every other byte
  // applies its make or break action and returns to IDLE. A rejected frame
  // drops any pending prefix but keeps the held keys as they are. Opposing
  // directions are not arbitrated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      p1_inputs <= 7'd0;
      p2_inputs <= 7'd0;
    end else if (frame_err) begin
      state <= ST_IDLE;
    end else if (rx_valid) begin
      if ((rx_byte == 8'hE0) && (state == ST_IDLE)) begin
        state <= ST_EXT;
      end else if ((rx_byte == 8'hF0) && (state == ST_IDLE)) begin
        state <= ST_BRK;
      end else if ((rx_byte == 8'hF0) && (state == ST_EXT)) begin
        state <= ST_EXT_BRK;
      end else begin
        state <= ST_IDLE;
        if (key_hit) begin
          if (key_p2) begin
            p2_inputs <= is_brk ? (p2_inputs & ~key_mask) : (p2_inputs | key_mask);
          end else begin
            p1_inputs <= is_brk ? (p1_inputs & ~key_mask) : (p1_inputs | key_mask);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_player_inputs.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ps2_player_inputs
//
// Directed testbench for ps2_player_inputs. It bit-bangs PS/2 frames, using
// a short timeout so that the abort path is reached quickly. Expected key
// vectors are worked out by hand from the scancode map.
// ---------------------------------------------------------------------------
module tb_ps2_player_inputs;

  localparam int  TIMEOUT = 200;
  localparam time HALF    = 100ns;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [6:0] p1_inputs;
  logic [6:0] p2_inputs;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int rv_count = 0;
  int fe_count = 0;
  int rv_run = 0;
  int rv_run_max = 0;
  int rv0;
  int fe0;

  ps2_player_inputs #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .p1_inputs (p1_inputs),
    .p2_inputs (p2_inputs),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  // Counts status pulses and tracks the longest rx_valid run
  always @(negedge clk) begin
    if (rx_valid) begin
      rv_count <= rv_count + 1;
      rv_run   <= rv_run + 1;
      if (rv_run + 1 > rv_run_max) rv_run_max <= rv_run + 1;
    end else begin
      rv_run <= 0;
    end
    if (frame_err) fe_count <= fe_count + 1;
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives the first 'edges' bits of a frame onto the PS/2 lines
  task automatic applyStimulus(input logic [7:0] code, input bit flip_parity,
                               input bit bad_stop, input bit bad_start, input int edges);
    logic [10:0] bits;
    bits[0]   = bad_start;
    bits[8:1] = code;
    bits[9]   = (~^code) ^ flip_parity;
    bits[10]  = ~bad_stop;
    for (int i = 0; i < edges; i++) begin
      ps2_data = bits[i];
      #(HALF);
      ps2_clk = 1'b0;
      #(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic sendByte(input logic [7:0] code);
    applyStimulus(code, 1'b0, 1'b0, 1'b0, 11);
    waitCycles(4);
  endtask

  task automatic snapshot();
    rv0 = rv_count;
    fe0 = fe_count;
  endtask

  initial begin
    $display("[TB] start");
    #30;
    waitCycles(1);
    checkOutput("rst_p1", p1_inputs, 0);
    checkOutput("rst_p2", p2_inputs, 0);
    checkOutput("rst_rx_byte", rx_byte, 0);
    checkOutput("rst_rx_valid", rx_valid, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    reset = 1'b1;
    waitCycles(5);

    // Make and break of player 1 left
    snapshot();
    sendByte(8'h1C);
    checkOutput("make1c_rx_byte", rx_byte, 8'h1C);
    checkOutput("make1c_rv_pulses", rv_count - rv0, 1);
    checkOutput("make1c_rv_width", rv_run_max, 1);
    checkOutput("make1c_p1", p1_inputs, 7'b0000010);
    sendByte(8'hF0);
    sendByte(8'h1C);
    checkOutput("brk1c_p1", p1_inputs, 7'b0000000);

    // Extended up for player 2
    sendByte(8'hE0);
    sendByte(8'h75);
    checkOutput("ext75_p2", p2_inputs, 7'b0001000);
    checkOutput("ext75_p1", p1_inputs, 7'b0000000);
    sendByte(8'hE0);
    sendByte(8'hF0);
    sendByte(8'h75);
    checkOutput("extbrk75_p2", p2_inputs, 7'b0000000);
    checkOutput("extbrk75_p1", p1_inputs, 7'b0000000);

    // E0 1C must not alias to plain left
    sendByte(8'hE0);
    sendByte(8'h1C);
    checkOutput("alias_p1", p1_inputs, 7'b0000000);
    checkOutput("alias_p2", p2_inputs, 7'b0000000);

    // Player 2 plain and extended keys together
    sendByte(8'h4B);
    checkOutput("p2_attack", p2_inputs, 7'b0100000);
    sendByte(8'hE0);
    sendByte(8'h6B);
    checkOutput("p2_attack_left", p2_inputs, 7'b0100010);
    sendByte(8'hF0);
    sendByte(8'h4B);
    checkOutput("p2_left_only", p2_inputs, 7'b0000010);
    sendByte(8'hE0);
    sendByte(8'hF0);
    sendByte(8'h6B);
    checkOutput("p2_clear", p2_inputs, 7'b0000000);

    // Typematic repeat, opposing directions, unmapped E1
    sendByte(8'h1C);
    sendByte(8'h1C);
    sendByte(8'h23);
    checkOutput("left_right_p1", p1_inputs, 7'b0000110);
    sendByte(8'hE1);
    checkOutput("e1_p1", p1_inputs, 7'b0000110);
    sendByte(8'hF0);
    sendByte(8'h1C);
    sendByte(8'hF0);
    sendByte(8'h23);
    checkOutput("left_right_clr", p1_inputs, 7'b0000000);

    // Frame 23 with even parity
    snapshot();
    applyStimulus(8'h23, 1'b1, 1'b0, 1'b0, 11);
    waitCycles(4);
`ifdef PS2_PARITY_CHECK_EN
    checkOutput("par_fe", fe_count - fe0, 1);
    checkOutput("par_rv", rv_count - rv0, 0);
    checkOutput("par_p1", p1_inputs, 7'b0000000);
`else
    checkOutput("par_fe", fe_count - fe0, 0);
    checkOutput("par_rv", rv_count - rv0, 1);
    checkOutput("par_p1", p1_inputs, 7'b0000100);
    sendByte(8'hF0);
    sendByte(8'h23);
`endif
    checkOutput("par_clr_p1", p1_inputs, 7'b0000000);

    // Bad stop bit after F0: the error drops the pending break
    sendByte(8'hF0);
    snapshot();
    applyStimulus(8'h1D, 1'b0, 1'b1, 1'b0, 11);
    waitCycles(4);
    checkOutput("stop_fe", fe_count - fe0, 1);
    checkOutput("stop_rv", rv_count - rv0, 0);
    checkOutput("stop_p1", p1_inputs, 7'b0000000);
    sendByte(8'h1C);
    checkOutput("after_err_make", p1_inputs, 7'b0000010);

    // A start bit sampled high is ignored without an error
    snapshot();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1);
    waitCycles(4);
    checkOutput("start1_fe", fe_count - fe0, 0);
    checkOutput("start1_rv", rv_count - rv0, 0);
    sendByte(8'h29);
    checkOutput("center_p1", p1_inputs, 7'b0000011);

    // Partial frame left hanging until the timeout fires
    snapshot();
    applyStimulus(8'h2B, 1'b0, 1'b0, 1'b0, 5);
    waitCycles(TIMEOUT + 20);
    checkOutput("timeout_fe", fe_count - fe0, 1);
    checkOutput("timeout_rv", rv_count - rv0, 0);
    sendByte(8'h2B);
    checkOutput("timeout_then_2b", p1_inputs, 7'b0100011);

    // Reset in the middle of a frame
    sendByte(8'hF0);
    sendByte(8'h2B);
    sendByte(8'hF0);
    sendByte(8'h29);
    sendByte(8'h23);
    checkOutput("held_left_right", p1_inputs, 7'b0000110);
    applyStimulus(8'h34, 1'b0, 1'b0, 1'b0, 4);
    reset = 1'b0;
    #20;
    waitCycles(1);
    checkOutput("midrst_p1", p1_inputs, 0);
    checkOutput("midrst_p2", p2_inputs, 0);
    checkOutput("midrst_rx_byte", rx_byte, 0);
    checkOutput("midrst_rx_valid", rx_valid, 0);
    checkOutput("midrst_frame_err", frame_err, 0);
    reset = 1'b1;
    waitCycles(5);
    sendByte(8'h34);
    checkOutput("post_rst_rx_byte", rx_byte, 8'h34);
    checkOutput("post_rst_p1", p1_inputs, 7'b1000000);
    checkOutput("rv_width_overall", rv_run_max, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
